// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control FSM: drives Counter enable/clear, lap snapshot and display select.
// Optional MAX_TIME saturation is compiled in with `define STOPWATCH_CTRL_SAT_EN.
module stopwatch_ctrl #(
  parameter int unsigned                   NUMBER_OF_NYBLES = 6,
  parameter logic [4*NUMBER_OF_NYBLES-1:0] MAX_TIME         = 'h595999,
  parameter int unsigned                   LAP_W            = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          btn_start_stop,
  input  logic                          btn_lap,
  input  logic                          btn_clear,
  input  logic [4*NUMBER_OF_NYBLES-1:0] time_in,
  output logic                          count_enable,
  output logic                          count_clear,
  output logic [4*NUMBER_OF_NYBLES-1:0] display_out,
  output logic [LAP_W-1:0]              lap_count,
  output logic [1:0]                    state_out
);

  localparam int unsigned TW = 4 * NUMBER_OF_NYBLES;

`ifdef STOPWATCH_CTRL_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StLap   = 2'd2,
    StPause = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     lap_q, lap_d;
  logic [TW-1:0]     display_q;
  logic [LAP_W-1:0]  lap_count_q, lap_count_d;
  logic              count_clear_q, count_clear_d;
  logic              running;
  logic              sat;

  assign running = (state_q == StRun) || (state_q == StLap);
  // Constant-folds to zero when saturation is not built in.
  assign sat     = SatEn && running && tick && (time_in == MAX_TIME);

  always_comb begin
    state_d       = state_q;
    lap_d         = lap_q;
    lap_count_d   = lap_count_q;
    count_clear_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_clear) begin
          count_clear_d = 1'b1;
          lap_count_d   = '0;
          lap_d         = '0;
        end else if (btn_start_stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (sat || btn_start_stop) begin
          state_d = StPause;
        end else if (btn_lap) begin
          state_d     = StLap;
          lap_d       = time_in;
          lap_count_d = lap_count_q + 1'b1;
        end
      end
      StLap: begin
        if (sat || btn_start_stop) begin
          state_d = StPause;
        end else if (btn_lap) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (btn_clear) begin
          state_d       = StIdle;
          count_clear_d = 1'b1;
          lap_count_d   = '0;
          lap_d         = '0;
        end else if (btn_start_stop) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      lap_q         <= '0;
      lap_count_q   <= '0;
      count_clear_q <= 1'b0;
      display_q     <= '0;
    end else begin
      state_q       <= state_d;
      lap_q         <= lap_d;
      lap_count_q   <= lap_count_d;
      count_clear_q <= count_clear_d;
      display_q     <= (state_q == StLap) ? lap_q : time_in;
    end
  end

  assign count_enable = tick && running && !sat;
  assign count_clear  = count_clear_q;
  assign display_out  = display_q;
  assign lap_count    = lap_count_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized traffic
// compared against a transition-table model of the stopwatch behaviour.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_CTRL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [23:0] MAXT = 24'h595999;
  localparam int IDLE = 0, RUN = 1, LAP = 2, PAUSE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic [23:0] time_in = '0;
  logic        count_enable;
  logic        count_clear;
  logic [23:0] display_out;
  logic [3:0]  lap_count;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          ms = IDLE;
  int          mcnt = 0;
  logic [23:0] mlapreg = '0;
  logic [23:0] mdisp = '0;
  bit          mcc = 1'b0;

  stopwatch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .btn_start_stop(btn_start_stop),
    .btn_lap       (btn_lap),
    .btn_clear     (btn_clear),
    .time_in       (time_in),
    .count_enable  (count_enable),
    .count_clear   (count_clear),
    .display_out   (display_out),
    .lap_count     (lap_count),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  function automatic bit m_sat();
    return SAT && (ms == RUN || ms == LAP) && tick && (time_in == MAXT);
  endfunction

  function automatic bit m_en();
    return tick && (ms == RUN || ms == LAP) && !m_sat();
  endfunction

  // Spec transition table, applied at each clock edge.
  task automatic m_step();
    bit sat;
    if (!rst) begin
      ms = IDLE; mcnt = 0; mlapreg = '0; mdisp = '0; mcc = 1'b0;
      return;
    end
    sat   = m_sat();
    mdisp = (ms == LAP) ? mlapreg : time_in;
    mcc   = 1'b0;
    case (ms)
      IDLE: if (btn_clear) begin mcc = 1'b1; mcnt = 0; mlapreg = '0; end
            else if (btn_start_stop) ms = RUN;
      RUN:  if (sat || btn_start_stop) ms = PAUSE;
            else if (btn_lap) begin ms = LAP; mlapreg = time_in; mcnt = (mcnt + 1) % 16; end
      LAP:  if (sat || btn_start_stop) ms = PAUSE;
            else if (btn_lap) ms = RUN;
      default: if (btn_clear) begin ms = IDLE; mcc = 1'b1; mcnt = 0; mlapreg = '0; end
               else if (btn_start_stop) ms = RUN;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle_inputs();
    btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; tick = 1'b0;
  endtask

  task automatic pulse_ss();
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b1; btn_start_stop = 1'b1; btn_lap = 1'b1; btn_clear = 1'b1;
    time_in = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state_out !== 2'd0 || display_out !== 24'h0 || lap_count !== 4'd0 ||
          count_clear !== 1'b0 || count_enable !== 1'b0) begin
        errors++;
        $display("FAIL reset: state=%0d disp=%h lap=%0d clr=%b en=%b want all 0",
                 state_out, display_out, lap_count, count_clear, count_enable);
      end
    end
    idle_inputs();
    rst = 1'b1;
    pulse_ss();
    checks++;
    if (state_out !== 2'd1) begin
      errors++; $display("FAIL reset_start: state=%0d want 1", state_out);
    end
  endtask

  task automatic test_run_ticks();
    int n = 0;
    time_in = 24'h0;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 4 == 0);
      #3;
      checks++;
      if (count_enable !== tick || count_enable !== m_en()) begin
        errors++; $display("FAIL run_tick[%0d]: en=%b want %b", i, count_enable, m_en());
      end
      if (count_enable === 1'b1) n++;
      step();
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL run_tick_count: got %0d want 10", n); end
    tick = 1'b0;
    pulse_ss();
    checks++;
    if (state_out !== 2'd3) begin errors++; $display("FAIL pause: state=%0d want 3", state_out); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1; #3;
      if (count_enable !== 1'b0) n++;
      step();
    end
    tick = 1'b0;
    checks++;
    if (n != 0) begin errors++; $display("FAIL pause_en: got %0d enables want 0", n); end
  endtask

  task automatic test_lap();
    pulse_ss();
    time_in = 24'h001234; btn_lap = 1'b1; step(); btn_lap = 1'b0;
    checks++;
    if (state_out !== 2'd2 || lap_count !== 4'd1) begin
      errors++; $display("FAIL lap_enter: state=%0d lap=%0d want 2/1", state_out, lap_count);
    end
    for (int k = 1; k <= 28; k++) begin
      time_in = 24'h001234 + 24'(k);
      step();
      checks++;
      if (display_out !== 24'h001234 || display_out !== mdisp) begin
        errors++; $display("FAIL lap_hold[%0d]: disp=%h want 001234", k, display_out);
      end
    end
    btn_lap = 1'b1; step(); btn_lap = 1'b0;
    checks++;
    if (state_out !== 2'd1 || lap_count !== 4'd1) begin
      errors++; $display("FAIL lap_exit: state=%0d lap=%0d want 1/1", state_out, lap_count);
    end
    time_in = 24'h001251; step();
    checks++;
    if (display_out !== 24'h001251) begin
      errors++; $display("FAIL lap_live: disp=%h want 001251", display_out);
    end
  endtask

  task automatic test_clear_priority();
    pulse_ss();
    btn_clear = 1'b1; btn_start_stop = 1'b1; step(); idle_inputs();
    checks++;
    if (state_out !== 2'd0 || count_clear !== 1'b1 || lap_count !== 4'd0) begin
      errors++;
      $display("FAIL clear_prio: state=%0d clr=%b lap=%0d want 0/1/0", state_out, count_clear,
               lap_count);
    end
    step();
    checks++;
    if (count_clear !== 1'b0 || state_out !== 2'd0) begin
      errors++; $display("FAIL clear_pulse: clr=%b state=%0d want 0/0", count_clear, state_out);
    end
  endtask

  task automatic test_saturation();
    pulse_ss();
    time_in = MAXT; tick = 1'b1; #3;
    checks++;
    if (count_enable !== !SAT) begin
      errors++; $display("FAIL sat_en: en=%b want %b", count_enable, !SAT);
    end
    step(); tick = 1'b0;
    checks++;
    if (state_out !== (SAT ? 2'd3 : 2'd1)) begin
      errors++; $display("FAIL sat_state: state=%0d want %0d", state_out, SAT ? 3 : 1);
    end
    if (SAT) begin
      pulse_ss();
      tick = 1'b1; #3;
      checks++;
      if (count_enable !== 1'b0) begin
        errors++; $display("FAIL sat_reenter_en: en=%b want 0", count_enable);
      end
      step(); tick = 1'b0;
      checks++;
      if (state_out !== 2'd3) begin
        errors++; $display("FAIL sat_reenter: state=%0d want 3", state_out);
      end
    end
    time_in = '0;
  endtask

  task automatic test_lap_wrap();
    rst = 1'b0; step(); rst = 1'b1;
    pulse_ss();
    for (int i = 0; i < 32; i++) begin
      btn_lap = 1'b1; step();
      btn_lap = 1'b0; step();
    end
    checks++;
    if (lap_count !== 4'd0 || state_out !== 2'd1 || lap_count !== 4'(mcnt)) begin
      errors++; $display("FAIL lap_wrap: lap=%0d state=%0d want 0/1", lap_count, state_out);
    end
    btn_clear = 1'b1; step(); btn_clear = 1'b0;
    checks++;
    if (count_clear !== 1'b0 || state_out !== 2'd1) begin
      errors++; $display("FAIL run_clear: clr=%b state=%0d want 0/1", count_clear, state_out);
    end
    step();
    checks++;
    if (count_clear !== 1'b0) begin
      errors++; $display("FAIL run_clear_late: clr=%b want 0", count_clear);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 63) != 0);
      tick           = ($urandom_range(0, 2) == 0);
      btn_start_stop = ($urandom_range(0, 7) == 0);
      btn_lap        = ($urandom_range(0, 4) == 0);
      btn_clear      = ($urandom_range(0, 7) == 0);
      time_in        = ($urandom_range(0, 5) == 0) ? MAXT : 24'($urandom);
      #3;
      checks++;
      if (count_enable !== m_en()) begin
        errors++; $display("FAIL rand_en[%0d]: en=%b want %b", i, count_enable, m_en());
      end
      step();
      checks++;
      if (state_out !== 2'(ms) || lap_count !== 4'(mcnt) || display_out !== mdisp ||
          count_clear !== mcc) begin
        errors++;
        $display("FAIL rand_regs[%0d]: state=%0d/%0d lap=%0d/%0d disp=%h/%h clr=%b/%b (got/want)",
                 i, state_out, ms, lap_count, mcnt, display_out, mdisp, count_clear, mcc);
      end
    end
    idle_inputs();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_lap();
    test_clear_priority();
    test_saturation();
    test_lap_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
